// File: rtl/traceback_row_fetcher_pkg.sv
// Shared widths and request-type codes for the traceback row fetcher and
// the prefetch row dealer downstream of it.
package traceback_row_fetcher_pkg;

   localparam int N               = 16;
   localparam int LOG_N           = 4;
   localparam int DIRECTION_WIDTH = 2;
   localparam int POSITION_WIDTH  = 8;
   localparam int ROW_WIDTH       = N * DIRECTION_WIDTH;

   localparam logic [1:0] TB_REQ_CURRENT  = 2'b01;
   localparam logic [1:0] TB_REQ_PREFETCH = 2'b10;

endpackage

// File: rtl/traceback_row_fetcher.sv
// Reads the two consecutive direction-memory words the prefetch row dealer
// needs for a traceback request, with a one-entry tag to skip repeat reads.
module traceback_row_fetcher
   import traceback_row_fetcher_pkg::*;
#(
   parameter int WORDS_PER_ROW = 4,
   parameter int ADDR_WIDTH    = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [POSITION_WIDTH-1:0] req_x,
   input  logic [POSITION_WIDTH-1:0] req_y,
   input  logic [1:0]                req_type,
   output logic                      mem_en,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   input  logic [ROW_WIDTH-1:0]      mem_rdata,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ROW_WIDTH-1:0]      row_k1,
   output logic [ROW_WIDTH-1:0]      row_k0,
   output logic [1:0]                prefetch_request,
   output logic [POSITION_WIDTH-1:0] in_block_y_startpoint,
   output logic [POSITION_WIDTH-1:0] prefetch_y_startpoint
);

   localparam int KW = $clog2(WORDS_PER_ROW);
   localparam logic [KW-1:0] LAST_K = KW'(WORDS_PER_ROW - 1);

   typedef enum logic [2:0] {IDLE, RD_K1, RD_K0, CAP, OUT} state_t;

   state_t                    state, next_state;
   logic [POSITION_WIDTH-1:0] x_q, tag_x, in_block_q, prefetch_q;
   logic [KW-1:0]             k_q, tag_k, req_k;
   logic [1:0]                type_q;
   logic                      tag_valid, last_q, ready_q, mem_en_q;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_next;
   logic                      accept, hit, mem_en_next;
   logic [ROW_WIDTH-1:0]      row_k1_q, row_k0_q;

   // WORDS_PER_ROW is a power of two, so x*WORDS_PER_ROW + k is a concatenation
   function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [POSITION_WIDTH-1:0] x,
                                                       input logic [KW-1:0] k);
      return ADDR_WIDTH'({x, k});
   endfunction

   assign req_k = KW'(req_y >> LOG_N);
   assign hit   = tag_valid && (req_x == tag_x) && (req_k == tag_k);

   always_comb begin
      next_state  = state;
      accept      = 1'b0;
      mem_en_next = 1'b0;
      addr_next   = '0;
      case (state)
         IDLE: begin
            if (ready_q && req_valid) begin
               accept = 1'b1;
               if (hit) begin
                  next_state = OUT;
               end else begin
                  next_state  = RD_K1;
                  mem_en_next = 1'b1;
                  addr_next   = word_addr(req_x, req_k);
               end
            end
         end
         RD_K1: begin
            if (k_q == LAST_K) begin
               next_state = CAP;
            end else begin
               next_state  = RD_K0;
               mem_en_next = 1'b1;
               addr_next   = word_addr(x_q, k_q + KW'(1));
            end
         end
         RD_K0:   next_state = CAP;
         CAP:     next_state = OUT;
         OUT:     if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Read enable/address are registered so the SRAM sees clean signals
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ready_q    <= 1'b0;
         mem_en_q   <= 1'b0;
         addr_q     <= '0;
         x_q        <= '0;
         k_q        <= '0;
         type_q     <= '0;
         in_block_q <= '0;
         prefetch_q <= '0;
         last_q     <= 1'b0;
         tag_valid  <= 1'b0;
         tag_x      <= '0;
         tag_k      <= '0;
         row_k1_q   <= '0;
         row_k0_q   <= '0;
      end else begin
         state    <= next_state;
         ready_q  <= (next_state == IDLE);
         mem_en_q <= mem_en_next;
         addr_q   <= addr_next;
         if (accept) begin
            x_q    <= req_x;
            k_q    <= req_k;
            type_q <= req_type;
            if (req_type == TB_REQ_PREFETCH)
               prefetch_q <= req_y;
            else
               in_block_q <= req_y;
         end
         if (state == RD_K1)
            last_q <= (k_q == LAST_K);
         if (state == RD_K0)
            row_k1_q <= mem_rdata;
         // The last word of a row has no successor, so row_k0 reads as zero
         if (state == CAP) begin
            if (last_q) begin
               row_k1_q <= mem_rdata;
               row_k0_q <= '0;
            end else begin
               row_k0_q <= mem_rdata;
            end
            tag_valid <= 1'b1;
            tag_x     <= x_q;
            tag_k     <= k_q;
         end
      end
   end

   assign req_ready             = ready_q;
   assign mem_en                = mem_en_q;
   assign mem_addr              = addr_q;
   assign out_valid             = (state == OUT);
   assign row_k1                = row_k1_q;
   assign row_k0                = row_k0_q;
   assign prefetch_request      = type_q;
   assign in_block_y_startpoint = in_block_q;
   assign prefetch_y_startpoint = prefetch_q;

endmodule

// File: tb/tb_traceback_row_fetcher.sv
// Directed bench for traceback_row_fetcher: miss, hit, last word,
// backpressure, mid-read reset and an unknown request type.
module tb_traceback_row_fetcher;
   import traceback_row_fetcher_pkg::*;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic                      req_valid = 1'b0;
   logic                      req_ready;
   logic [POSITION_WIDTH-1:0] req_x = '0;
   logic [POSITION_WIDTH-1:0] req_y = '0;
   logic [1:0]                req_type = '0;
   logic                      mem_en;
   logic [9:0]                mem_addr;
   logic [ROW_WIDTH-1:0]      mem_rdata = '0;
   logic                      out_valid;
   logic                      out_ready = 1'b0;
   logic [ROW_WIDTH-1:0]      row_k1, row_k0;
   logic [1:0]                prefetch_request;
   logic [POSITION_WIDTH-1:0] in_block_y_startpoint, prefetch_y_startpoint;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   traceback_row_fetcher #(.WORDS_PER_ROW(4), .ADDR_WIDTH(10)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_type(req_type),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .row_k1(row_k1), .row_k0(row_k0),
      .prefetch_request(prefetch_request),
      .in_block_y_startpoint(in_block_y_startpoint),
      .prefetch_y_startpoint(prefetch_y_startpoint)
   );

   always #5 clk = ~clk;

   // Synchronous SRAM model: word at address a holds 32'hC0DE_0000 | a
   always @(posedge clk) begin
      if (mem_en) mem_rdata <= {16'hC0DE, 6'b0, mem_addr};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [1:0] t);
      req_valid = 1'b1;
      req_x     = x;
      req_y     = y;
      req_type  = t;
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("rst_req_ready", req_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_row_k1", row_k1, 0);
      rst = 1'b0;
      step();
      check("ready_after_rst", req_ready, 1);

      // Miss: x=2, y=21 -> k=1, addresses 9 then 10
      send(8'd2, 8'd21, 2'b01);
      step();
      req_valid = 1'b0;
      check("miss_c1_en", mem_en, 1);
      check("miss_c1_addr", mem_addr, 9);
      check("miss_c1_ready", req_ready, 0);
      step();
      check("miss_c2_en", mem_en, 1);
      check("miss_c2_addr", mem_addr, 10);
      step();
      check("miss_c3_en", mem_en, 0);
      check("miss_c3_addr", mem_addr, 0);
      check("miss_c3_valid", out_valid, 0);
      step();
      check("miss_c4_valid", out_valid, 1);
      check("miss_row_k1", row_k1, 32'hC0DE0009);
      check("miss_row_k0", row_k0, 32'hC0DE000A);
      check("miss_inblock_y", in_block_y_startpoint, 21);
      check("miss_type", prefetch_request, 2'b01);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("miss_done_valid", out_valid, 0);
      check("miss_done_ready", req_ready, 1);
      check("miss_rows_held", row_k1, 32'hC0DE0009);

      // Hit: x=2, y=18 -> same word pair, prefetch type
      send(8'd2, 8'd18, 2'b10);
      step();
      req_valid = 1'b0;
      check("hit_valid", out_valid, 1);
      check("hit_no_mem", mem_en, 0);
      check("hit_row_k1", row_k1, 32'hC0DE0009);
      check("hit_row_k0", row_k0, 32'hC0DE000A);
      check("hit_pref_y", prefetch_y_startpoint, 18);
      check("hit_inblock_y", in_block_y_startpoint, 21);
      check("hit_type", prefetch_request, 2'b10);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Last word: x=1, y=63 -> k=3, single read at 7
      send(8'd1, 8'd63, 2'b01);
      step();
      req_valid = 1'b0;
      check("last_c1_en", mem_en, 1);
      check("last_c1_addr", mem_addr, 7);
      step();
      check("last_c2_en", mem_en, 0);
      check("last_c2_valid", out_valid, 0);
      step();
      check("last_c3_valid", out_valid, 1);
      check("last_row_k1", row_k1, 32'hC0DE0007);
      check("last_row_k0", row_k0, 0);

      // Backpressure with a pending request
      send(8'd3, 8'd0, 2'b01);
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_valid", out_valid, 1);
         check("bp_ready", req_ready, 0);
         check("bp_row_k1", row_k1, 32'hC0DE0007);
         check("bp_mem_en", mem_en, 0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_release_valid", out_valid, 0);
      check("bp_release_ready", req_ready, 1);
      step();
      req_valid = 1'b0;
      check("bp_next_en", mem_en, 1);
      check("bp_next_addr", mem_addr, 12);
      step();
      check("rdk0_addr", mem_addr, 13);

      // Reset while in RD_K0
      rst = 1'b1;
      step();
      check("mid_rst_en", mem_en, 0);
      check("mid_rst_ready", req_ready, 0);
      check("mid_rst_row_k1", row_k1, 0);
      check("mid_rst_row_k0", row_k0, 0);
      check("mid_rst_inblock", in_block_y_startpoint, 0);
      check("mid_rst_type", prefetch_request, 0);
      rst = 1'b0;
      step();
      check("post_rst_ready", req_ready, 1);
      check("post_rst_row_k1", row_k1, 0);

      // Repeat of x=2, y=21 must miss because the tag was cleared
      send(8'd2, 8'd21, 2'b01);
      step();
      req_valid = 1'b0;
      check("rep_c1_addr", mem_addr, 9);
      check("rep_c1_en", mem_en, 1);
      step();
      check("rep_c2_addr", mem_addr, 10);
      step();
      step();
      check("rep_valid", out_valid, 1);
      check("rep_row_k1", row_k1, 32'hC0DE0009);
      check("rep_row_k0", row_k0, 32'hC0DE000A);
      out_ready = 1'b1;
      step();

      // Unknown type 11 with out_ready held high throughout
      send(8'd0, 8'd5, 2'b11);
      step();
      req_valid = 1'b0;
      check("t11_c1_en", mem_en, 1);
      check("t11_c1_valid", out_valid, 0);
      step();
      check("t11_c2_addr", mem_addr, 1);
      step();
      check("t11_c3_valid", out_valid, 0);
      step();
      check("t11_valid", out_valid, 1);
      check("t11_inblock_y", in_block_y_startpoint, 5);
      check("t11_type", prefetch_request, 2'b11);
      check("t11_pref_y", prefetch_y_startpoint, 0);
      check("t11_row_k1", row_k1, 32'hC0DE0000);
      check("t11_row_k0", row_k0, 32'hC0DE0001);
      step();
      out_ready = 1'b0;
      check("t11_done_valid", out_valid, 0);
      check("t11_done_ready", req_ready, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/traceback_row_fetcher.md
# traceback_row_fetcher

Sequential stage directly upstream of the traceback prefetch row dealer. It accepts a traceback row request (x row, y startpoint, request type) and reads the two consecutive direction-memory words the dealer needs. It then presents them as `row_k1`/`row_k0` with the matching startpoints and `prefetch_request` code, under a valid/ready handshake. A one-entry tag avoids re-reading when consecutive requests fall in the same word pair.

## Interface
- `WORDS_PER_ROW`, default 4: direction-memory words per DP row; power of two, ≥2.
- `ADDR_WIDTH`, default 10: direction-memory address width.
- Widths `N`, `log_N`, `DIRECTION_WIDTH` and `POSITION_WIDTH` come from `define.v`.
- One clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  high only in IDLE.
- `req_x`  in  POSITION_WIDTH  DP row index.
- `req_y`  in  POSITION_WIDTH  y startpoint.
- `req_type`  in  2  2'b01 current, 2'b10 prefetch; other codes are treated as current.
- `mem_en`  out  1  synchronous SRAM read enable.
- `mem_addr`  out  ADDR_WIDTH  read address.
- `mem_rdata`  in  N*DIRECTION_WIDTH  read data, valid the cycle after `mem_en`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `row_k1`  out  N*DIRECTION_WIDTH  word k (the word containing y).
- `row_k0`  out  N*DIRECTION_WIDTH  word k+1; zero when k is the last word of the row.
- `prefetch_request`  out  2  registered `req_type`.
- `in_block_y_startpoint`  out  POSITION_WIDTH  last y accepted with a current-type request.
- `prefetch_y_startpoint`  out  POSITION_WIDTH  last y accepted with type 2'b10.

## Operation
- Word index: k = (`req_y` >> log_N) mod `WORDS_PER_ROW`.
- Address: `mem_addr` = `req_x`*`WORDS_PER_ROW` + k, truncated to `ADDR_WIDTH`.
- Second read: k+1, computed within the same row (no carry into x).
- FSM states: IDLE, RD_K1, RD_K0, CAP, OUT.
- IDLE: `req_ready`=1. On accept, register x, k, type and y (y goes into the startpoint register selected by type).
  - Tag hit (tag valid, x and k equal to the held pair): go to OUT. No memory access.
  - Miss: go to RD_K1.
- RD_K1: `mem_en`=1 at address k.
  - If k == `WORDS_PER_ROW`-1, next state is CAP with the last-word flag set.
  - Otherwise next state is RD_K0.
- RD_K0: `mem_en`=1 at address k+1; capture `mem_rdata` into `row_k1`.
- CAP: capture `mem_rdata` into `row_k0`, or into `row_k1` with `row_k0`=0 when the last-word flag is set. Load the tag and set tag valid. Next state is OUT.
- OUT: `out_valid`=1. All outputs hold until `out_ready`=1, then go to IDLE.
- The held rows remain on `row_k1`/`row_k0` after the handshake, so the dealer can keep reading them.
- Reset values:
  - All outputs 0, including `req_ready`; `req_ready` rises on the first cycle after reset.
  - Tag invalid; state IDLE.
- Reset in any state abandons the transaction. Read data returning the cycle after reset is ignored.
- `out_ready`=1 while not in OUT has no effect.

## Timing
- Miss, k not last: accept at cycle 0; `mem_en` in cycles 1 and 2; `out_valid` from cycle 4 (CAP occupies cycle 3).
- Miss, k last: one read in cycle 1; `out_valid` from cycle 3.
- Hit: `out_valid` from cycle 1.
- Completing the output handshake in cycle t puts the block in IDLE with `req_ready`=1 at t+1. There is no accept/complete overlap, so throughput is at most one request per 2 cycles.
- `mem_addr` is registered and driven only while `mem_en`=1; it is 0 otherwise.

## Structure
- Add `TB_REQ_CURRENT` (2'b01) and `TB_REQ_PREFETCH` (2'b10) to `define.v`; the dealer and this block share them.
- FSM state encodings stay local to the module.
- Single module, no sub-module. The tag compare and address generation are inline combinational logic.

## Test plan
- N=16, `WORDS_PER_ROW`=4, miss: x=2, y=21, type 01 → `mem_addr` 9 then 10 in consecutive cycles; `out_valid` 4 cycles after accept; `row_k1`=word 9, `row_k0`=word 10; `in_block_y_startpoint`=21; `prefetch_request`=01.
- Hit following the miss: x=2, y=18, type 10 → no `mem_en`; `out_valid` 1 cycle after accept; rows unchanged; `prefetch_y_startpoint`=18; `in_block_y_startpoint` stays 21.
- Last word: x=1, y=63 → single read at address 7; `row_k0`=0; `out_valid` 3 cycles after accept.
- Backpressure: `out_ready`=0 for 5 cycles while `req_valid`=1 → all outputs stable; `req_ready`=0; no new request is accepted until the cycle after `out_ready`=1.
- Reset asserted during RD_K0 → next cycle all outputs 0 and `mem_en`=0. A repeat of x=2, y=21 is a miss with addresses 9 and 10.
- `req_type`=2'b11, y=5 → `in_block_y_startpoint`=5; `prefetch_request`=11.
